multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Main control FSM of the multi-cycle CPU; sequences instruction register (IR) load, PC update, memory access, register write.
//   Decodes opcode/funct from IR, steps each instruction through IF/ID/EX/MEM/WB, stalls on memory handshake.
//   Subset: R-type(000000) lw(100011) sw(101011) beq(000100) j(000010) addi(001000); any other opcode is illegal.
// PARAMETERS
//   CNT_W    32  width of retired-instruction counter
//   TIMEOUT  15  max wait cycles for mem_ready in IF/MEM; 0 = wait forever
// PORTS
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   opcode       in   6      IR[31:26]; stable from ID until instruction retires
//   funct        in   6      IR[5:0]
//   zero         in   1      ALU zero flag, valid in EX
//   mem_ready    in   1      memory done; read data/write complete this cycle
//   ir_in        out  1      IR load strobe
//   pc_write     out  1      unconditional PC write
//   pc_src       out  2      0 = ALU (PC+4), 1 = ALUOut (branch target), 2 = jump address
//   iord         out  1      0 = address from PC, 1 = from ALUOut
//   mem_read     out  1      memory read request
//   mem_write    out  1      memory write request
//   alu_src_a    out  1      0 = PC, 1 = rs
//   alu_src_b    out  2      0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = imm<<2
//   alu_op       out  2      0 = add, 1 = sub, 2 = use funct
//   reg_write    out  1      register file write enable
//   reg_dst      out  1      0 = rt, 1 = rd
//   mem_to_reg   out  1      0 = ALUOut, 1 = MDR
//   illegal      out  1      1-cycle pulse: illegal opcode decoded
//   mem_err      out  1      1-cycle pulse: mem_ready timeout
//   state        out  3      IF=0 ID=1 EX=2 MEM=3 WB=4
//   retired      out  CNT_W  count of completed instructions, wraps at 2^CNT_W
// BEHAVIOUR
//   - rst high: state=IF, retired=0, wait counter=0; all strobes forced 0 while rst high. First cycle after release is IF.
//   - Control outputs are combinational from state, opcode and zero. Unlisted outputs are 0.
//   - IF: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0.
//       On mem_ready: ir_in=1, pc_write=1, pc_src=0, next ID. Otherwise stay in IF.
//   - ID: alu_src_a=0, alu_src_b=3, alu_op=0 (precompute branch target).
//       j: pc_write=1, pc_src=2, retire, next IF.
//       illegal: illegal=1, no retire, next IF.
//       All other opcodes: next EX.
//   - EX:
//       R-type: alu_src_a=1, alu_src_b=0, alu_op=2, next WB.
//       addi/lw/sw: alu_src_a=1, alu_src_b=2, alu_op=0; addi next WB, lw/sw next MEM.
//       beq: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1, pc_write=zero, retire, next IF.
//   - MEM: iord=1; lw holds mem_read=1, sw holds mem_write=1, held until mem_ready.
//       lw + mem_ready: next WB.
//       sw + mem_ready: retire, next IF.
//   - WB: reg_write=1; reg_dst=1 for R-type, else 0; mem_to_reg=1 for lw only. Retire, next IF.
//   - Retire: retired += 1 on the clock edge leaving the final state.
//   - Wait counter: clears on entry to IF/MEM, increments each cycle mem_ready=0.
//       If TIMEOUT!=0 and counter==TIMEOUT with mem_ready=0: mem_err pulse, all strobes 0 that cycle, no retire, next IF.
//       mem_ready on the timeout cycle wins (normal completion).
//   - Async rst mid-instruction aborts it immediately: no partial reg_write/mem_write after the rst edge; retired unchanged... then 0.
//   - Latency with mem_ready=1 always:
//       j = 2 cycles; beq = 3; R-type / addi / sw = 4; lw = 5.
// TESTING
//   1. Reset: rst at MEM of sw (mem_write=1) -> mem_write=0 same cycle, state=0, retired=0; release -> IF, mem_read=1.
//   2. add (op 000000, funct 100000), mem_ready=1: states 0,1,2,4.
//      ir_in only in cycle 1; cycle 4 reg_write=1, reg_dst=1; retired 0->1.
//   3. lw, mem_ready low 3 cycles in MEM: MEM held 4 cycles with mem_read=1, iord=1; then WB mem_to_reg=1; 8 cycles total.
//   4. beq zero=1 -> EX pc_write=1, pc_src=1. beq zero=0 -> pc_write=0. Both 3 cycles, retired +1.
//   5. Opcode 111111 -> illegal=1 in ID for 1 cycle, retired unchanged, next IF.
//      j -> pc_src=2 in ID, 2 cycles.
//   6. TIMEOUT=15, mem_ready never asserts in IF:
//      mem_err pulses in the 16th IF cycle; ir_in never asserted; re-enter IF.
//      Also retired at 2^CNT_W-1 wraps to 0 on next retire.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control FSM of the multi-cycle CPU. Each instruction steps through
//   IF/ID/EX/MEM/WB. The FSM drives the datapath mux selects and strobes, and
//   it stalls in IF/MEM until the memory handshake (mem_ready) completes.
//   Supported opcodes are R-type, lw, sw, beq, j and addi. Any other opcode is
//   flagged as illegal in ID.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   opcode, funct        IR fields (funct is decoded by the ALU control, not here)
//   zero                 ALU zero flag, used by beq in EX
//   mem_ready            memory access completes this cycle
//   ir_in .. mem_to_reg  datapath control strobes and mux selects
//   illegal, mem_err     one-cycle error pulses
//   state                current FSM state (IF=0 ID=1 EX=2 MEM=3 WB=4)
//   retired              count of completed instructions (wraps)
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_in,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             mem_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam int              WAIT_W = 16;
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT);

  state_t            st_q, st_d;
  logic [WAIT_W-1:0] wcnt_q;
  logic              retire;
  logic              wait_clr;
  logic              waiting;
  logic              timeout_hit;
  logic              funct_unused;

  // funct only matters to the ALU control unit downstream.
  assign funct_unused = ^funct;

  assign state       = st_q;
  assign waiting     = (st_q == S_IF) || (st_q == S_MEM);
  // A mem_ready that arrives on the timeout cycle completes the access normally.
  assign timeout_hit = (TIMEOUT != 0) && waiting && !mem_ready && (wcnt_q == TO_VAL);

  always_comb begin
    st_d       = st_q;
    retire     = 1'b0;
    ir_in      = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;

    unique case (st_q)
      S_IF: begin
        if (timeout_hit) begin
          mem_err = 1'b1;
          st_d    = S_IF;
        end else begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          if (mem_ready) begin
            ir_in    = 1'b1;
            pc_write = 1'b1;
            st_d     = S_ID;
          end
        end
      end
      S_ID: begin
        // Speculatively form the branch target while decoding.
        alu_src_b = 2'd3;
        unique case (opcode)
          OP_J: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            retire   = 1'b1;
            st_d     = S_IF;
          end
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: st_d = S_EX;
          default: begin
            illegal = 1'b1;
            st_d    = S_IF;
          end
        endcase
      end
      S_EX: begin
        alu_src_a = 1'b1;
        unique case (opcode)
          OP_R: begin
            alu_op = 2'd2;
            st_d   = S_WB;
          end
          OP_ADDI: begin
            alu_src_b = 2'd2;
            st_d      = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 2'd2;
            st_d      = S_MEM;
          end
          OP_BEQ: begin
            alu_op   = 2'd1;
            pc_src   = 2'd1;
            pc_write = zero;
            retire   = 1'b1;
            st_d     = S_IF;
          end
          default: st_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (timeout_hit) begin
          mem_err = 1'b1;
          st_d    = S_IF;
        end else begin
          iord      = 1'b1;
          mem_read  = (opcode == OP_LW);
          mem_write = (opcode != OP_LW);
          if (mem_ready) begin
            if (opcode == OP_LW) begin
              st_d = S_WB;
            end else begin
              retire = 1'b1;
              st_d   = S_IF;
            end
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_R);
        mem_to_reg = (opcode == OP_LW);
        retire     = 1'b1;
        st_d       = S_IF;
      end
      default: st_d = S_IF;
    endcase

    // The wait counter restarts whenever IF or MEM is (re)entered.
    wait_clr = timeout_hit || (((st_d == S_IF) || (st_d == S_MEM)) && (st_d != st_q));

    // While reset is held no strobe may reach the datapath.
    if (rst) begin
      retire     = 1'b0;
      ir_in      = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      mem_err    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IF;
      wcnt_q  <= '0;
      retired <= '0;
    end else begin
      st_q    <= st_d;
      retired <= retired + CNT_W'(retire);
      if (wait_clr) begin
        wcnt_q <= '0;
      end else if (waiting && !mem_ready) begin
        wcnt_q <= wcnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       ir_in;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       mem_err;
  } ctrl_t;

  typedef struct packed {
    logic [2:0] st;
    ctrl_t      c;
    logic [3:0] ret;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'b100000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       ir_in, pc_write, iord, mem_read, mem_write, alu_src_a;
  logic       reg_write, reg_dst, mem_to_reg, illegal, mem_err;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [2:0] state;
  logic [3:0] retired;

  ctrl_t      act;
  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] ret = 4'd0;
  string      tname = "reset";

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ir_in(ir_in), .pc_write(pc_write), .pc_src(pc_src),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .mem_err(mem_err), .state(state), .retired(retired)
  );

  assign act = '{ir_in, pc_write, pc_src, iord, mem_read, mem_write, alu_src_a,
                 alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal, mem_err};

  // Expected control words, written out from the behaviour table by hand.
  function automatic ctrl_t c_zero();
    ctrl_t c = '0;
    return c;
  endfunction
  function automatic ctrl_t c_if(input logic mr);
    ctrl_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'd1;
    c.ir_in = mr; c.pc_write = mr;
    return c;
  endfunction
  function automatic ctrl_t c_id();
    ctrl_t c = '0;
    c.alu_src_b = 2'd3;
    return c;
  endfunction
  function automatic ctrl_t c_id_j();
    ctrl_t c = '0;
    c.alu_src_b = 2'd3; c.pc_write = 1'b1; c.pc_src = 2'd2;
    return c;
  endfunction
  function automatic ctrl_t c_id_ill();
    ctrl_t c = '0;
    c.alu_src_b = 2'd3; c.illegal = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t c_ex_r();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 2'd2;
    return c;
  endfunction
  function automatic ctrl_t c_ex_imm();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
    return c;
  endfunction
  function automatic ctrl_t c_ex_beq(input logic z);
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 2'd1; c.pc_src = 2'd1; c.pc_write = z;
    return c;
  endfunction
  function automatic ctrl_t c_mem(input logic is_lw);
    ctrl_t c = '0;
    c.iord = 1'b1; c.mem_read = is_lw; c.mem_write = ~is_lw;
    return c;
  endfunction
  function automatic ctrl_t c_wb(input logic rd, input logic m2r);
    ctrl_t c = '0;
    c.reg_write = 1'b1; c.reg_dst = rd; c.mem_to_reg = m2r;
    return c;
  endfunction
  function automatic ctrl_t c_err();
    ctrl_t c = '0;
    c.mem_err = 1'b1;
    return c;
  endfunction

  // Drive one cycle of stimulus and queue the response expected in that cycle.
  task automatic step(input logic r, input logic [5:0] op, input logic z,
                      input logic mr, input logic [2:0] st, input ctrl_t c);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; opcode = op; zero = z; mem_ready = mr;
    e.st = st; e.c = c; e.ret = ret;
    q.push_back(e);
  endtask

  task automatic do_j();
    step(1'b0, OP_J, 1'b0, 1'b1, 3'd0, c_if(1'b1));
    step(1'b0, OP_J, 1'b0, 1'b1, 3'd1, c_id_j());
    ret = ret + 4'd1;
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (state !== e.st || act !== e.c || retired !== e.ret) begin
        n_bad++;
        $display("FAIL %s t=%0t: got state=%0d ctrl=%h retired=%0d, want state=%0d ctrl=%h retired=%0d",
                 tname, $time, state, act, retired, e.st, e.c, e.ret);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: everything quiet.
    step(1'b1, OP_R, 1'b0, 1'b0, 3'd0, c_zero());
    step(1'b1, OP_R, 1'b0, 1'b1, 3'd0, c_zero());

    tname = "add";
    step(1'b0, OP_R, 1'b0, 1'b1, 3'd0, c_if(1'b1));
    step(1'b0, OP_R, 1'b0, 1'b1, 3'd1, c_id());
    step(1'b0, OP_R, 1'b0, 1'b1, 3'd2, c_ex_r());
    step(1'b0, OP_R, 1'b0, 1'b1, 3'd4, c_wb(1'b1, 1'b0));
    ret = ret + 4'd1;

    tname = "lw_stall";
    step(1'b0, OP_LW, 1'b0, 1'b1, 3'd0, c_if(1'b1));
    step(1'b0, OP_LW, 1'b0, 1'b1, 3'd1, c_id());
    step(1'b0, OP_LW, 1'b0, 1'b1, 3'd2, c_ex_imm());
    for (int i = 0; i < 3; i++) step(1'b0, OP_LW, 1'b0, 1'b0, 3'd3, c_mem(1'b1));
    step(1'b0, OP_LW, 1'b0, 1'b1, 3'd3, c_mem(1'b1));
    step(1'b0, OP_LW, 1'b0, 1'b1, 3'd4, c_wb(1'b0, 1'b1));
    ret = ret + 4'd1;

    tname = "beq_taken";
    step(1'b0, OP_BEQ, 1'b1, 1'b1, 3'd0, c_if(1'b1));
    step(1'b0, OP_BEQ, 1'b1, 1'b1, 3'd1, c_id());
    step(1'b0, OP_BEQ, 1'b1, 1'b1, 3'd2, c_ex_beq(1'b1));
    ret = ret + 4'd1;

    tname = "beq_not_taken";
    step(1'b0, OP_BEQ, 1'b0, 1'b1, 3'd0, c_if(1'b1));
    step(1'b0, OP_BEQ, 1'b0, 1'b1, 3'd1, c_id());
    step(1'b0, OP_BEQ, 1'b0, 1'b1, 3'd2, c_ex_beq(1'b0));
    ret = ret + 4'd1;

    tname = "illegal";
    step(1'b0, OP_BAD, 1'b0, 1'b1, 3'd0, c_if(1'b1));
    step(1'b0, OP_BAD, 1'b0, 1'b1, 3'd1, c_id_ill());

    tname = "jump";
    do_j();

    tname = "addi";
    step(1'b0, OP_ADDI, 1'b0, 1'b1, 3'd0, c_if(1'b1));
    step(1'b0, OP_ADDI, 1'b0, 1'b1, 3'd1, c_id());
    step(1'b0, OP_ADDI, 1'b0, 1'b1, 3'd2, c_ex_imm());
    step(1'b0, OP_ADDI, 1'b0, 1'b1, 3'd4, c_wb(1'b0, 1'b0));
    ret = ret + 4'd1;

    tname = "sw_reset_abort";
    step(1'b0, OP_SW, 1'b0, 1'b1, 3'd0, c_if(1'b1));
    step(1'b0, OP_SW, 1'b0, 1'b1, 3'd1, c_id());
    step(1'b0, OP_SW, 1'b0, 1'b1, 3'd2, c_ex_imm());
    step(1'b0, OP_SW, 1'b0, 1'b0, 3'd3, c_mem(1'b0));
    step(1'b0, OP_SW, 1'b0, 1'b0, 3'd3, c_mem(1'b0));
    ret = 4'd0;
    step(1'b1, OP_SW, 1'b0, 1'b0, 3'd0, c_zero());
    step(1'b1, OP_SW, 1'b0, 1'b1, 3'd0, c_zero());

    tname = "if_timeout";
    for (int i = 0; i < 15; i++) step(1'b0, OP_J, 1'b0, 1'b0, 3'd0, c_if(1'b0));
    step(1'b0, OP_J, 1'b0, 1'b0, 3'd0, c_err());
    do_j();

    tname = "retired_wrap";
    for (int i = 0; i < 15; i++) do_j();
    step(1'b0, OP_J, 1'b0, 1'b0, 3'd0, c_if(1'b0));

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
